// File: rtl/ex_div_seq.sv
// ----------------------------------------------------------------------------
// ex_div_seq
//
// Multi-cycle integer divide sequencer for the EX stage (DIV / DIVU).
// EX holds i_start high with both operands. The block runs a restoring
// shift-subtract loop, one quotient bit per cycle, and stalls the pipeline
// while it works. It then presents the quotient (for lo) and the remainder
// (for hi) until EX drops i_start.
//
// Ports
//   i_clk        core clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_start      divide request, held high until the result is consumed
//   i_signed     1 = DIV (two's complement), 0 = DIVU
//   i_annul      pipeline flush; aborts any divide in flight
//   i_op0        dividend (rs)
//   i_op1        divisor (rt)
//   o_stall_req  combinational freeze request for IF..EX
//   o_ready      result valid (registered)
//   o_quot       quotient
//   o_rem        remainder
//   o_dbg_state  current FSM state (0 IDLE, 1 BY_ZERO, 2 RUN, 3 DONE)
//
// Handshake: the result is valid while o_ready=1. EX consumes it by dropping
// i_start, which returns the block to IDLE on the next edge. o_stall_req is
// low in the same cycle o_ready is high, so EX advances with the result.
// ----------------------------------------------------------------------------
module ex_div_seq #(
    parameter int N_REG = 32,
    parameter int N_CNT = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_annul,
    input  logic [N_REG-1:0] i_op0,
    input  logic [N_REG-1:0] i_op1,
    output logic             o_stall_req,
    output logic             o_ready,
    output logic [N_REG-1:0] o_quot,
    output logic [N_REG-1:0] o_rem,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BY_ZERO = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_CNT-1:0]   cnt_q, cnt_d;
    logic [N_REG-1:0]   dvd_q, dvd_d;       // dividend magnitude, shifts left
    logic [N_REG-1:0]   dvs_q, dvs_d;       // divisor magnitude
    // The partial remainder never reaches 2**(N_REG-1) between iterations:
    // it is bounded by the dividend bits consumed so far, at most N_REG-1.
    // Only the low N_REG-1 bits are kept.
    logic [N_REG-2:0]   prem_q, prem_d;
    // Working quotient: only the low N_REG-1 bits are carried forward; the
    // final bit is appended when the loop finishes.
    logic [N_REG-2:0]   quot_q, quot_d;
    logic               sgn_q, sgn_d;
    logic               neg0_q, neg0_d;
    logic               neg1_q, neg1_d;
    logic               ready_q, ready_d;
    logic [N_REG-1:0]   quot_out_q, quot_out_d;
    logic [N_REG-1:0]   rem_out_q, rem_out_d;

    // One restoring iteration
    logic [N_REG-1:0]   shifted;
    logic [N_REG:0]     trial;
    logic               borrow;
    logic [N_REG-1:0]   prem_nxt;
    logic [N_REG-1:0]   quot_nxt;
    logic               last_iter;

    assign shifted   = {prem_q, dvd_q[N_REG-1]};
    assign trial     = {1'b0, shifted} - {1'b0, dvs_q};
    assign borrow    = trial[N_REG];
    assign prem_nxt  = borrow ? shifted : trial[N_REG-1:0];
    assign quot_nxt  = {quot_q, ~borrow};
    assign last_iter = (cnt_q == N_CNT'(N_REG - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            prem_q     <= '0;
            quot_q     <= '0;
            sgn_q      <= 1'b0;
            neg0_q     <= 1'b0;
            neg1_q     <= 1'b0;
            ready_q    <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            prem_q     <= prem_d;
            quot_q     <= quot_d;
            sgn_q      <= sgn_d;
            neg0_q     <= neg0_d;
            neg1_q     <= neg1_d;
            ready_q    <= ready_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        prem_d     = prem_q;
        quot_d     = quot_q;
        sgn_d      = sgn_q;
        neg0_d     = neg0_q;
        neg1_d     = neg1_q;
        ready_d    = ready_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;

        if (i_annul) begin
            // Flush wins over everything; the held result registers are left
            // alone, but o_ready drops so nothing partial is ever presented.
            state_d = ST_IDLE;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_op1 == '0) begin
                            state_d = ST_BY_ZERO;
                        end else begin
                            state_d = ST_RUN;
                            dvd_d   = (i_signed && i_op0[N_REG-1]) ? -i_op0 : i_op0;
                            dvs_d   = (i_signed && i_op1[N_REG-1]) ? -i_op1 : i_op1;
                            neg0_d  = i_op0[N_REG-1];
                            neg1_d  = i_op1[N_REG-1];
                            sgn_d   = i_signed;
                            prem_d  = '0;
                            quot_d  = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_BY_ZERO: begin
                    state_d    = ST_DONE;
                    ready_d    = 1'b1;
                    quot_out_d = '0;
                    rem_out_d  = '0;
                end
                ST_RUN: begin
                    prem_d = prem_nxt[N_REG-2:0];
                    quot_d = quot_nxt[N_REG-2:0];
                    dvd_d  = dvd_q << 1;
                    cnt_d  = cnt_q + N_CNT'(1);
                    if (last_iter) begin
                        state_d    = ST_DONE;
                        ready_d    = 1'b1;
                        // Sign fix-up: quotient negative when signs differ,
                        // remainder takes the dividend's sign. The most
                        // negative value divided by -1 wraps back to itself.
                        quot_out_d = (sgn_q && (neg0_q ^ neg1_q)) ? -quot_nxt : quot_nxt;
                        rem_out_d  = (sgn_q && neg0_q) ? -prem_nxt : prem_nxt;
                    end
                end
                ST_DONE: begin
                    if (!i_start) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign o_stall_req = i_start & ~i_annul & (state_q != ST_DONE);
    assign o_ready     = ready_q;
    assign o_quot      = quot_out_q;
    assign o_rem       = rem_out_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Testbench for ex_div_seq: randomized and directed divides. Expected results
// come from a plain-arithmetic reference model and are queued at launch; a
// monitor pops and compares each time o_ready rises.
module tb_ex_div_seq;

    localparam int N = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          sgn;
    logic          annul;
    logic [N-1:0]  op0;
    logic [N-1:0]  op1;
    logic          stall;
    logic          rdy;
    logic [N-1:0]  quot;
    logic [N-1:0]  rem;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    ex_div_seq #(.N_REG(N), .N_CNT(6)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_signed    (sgn),
        .i_annul     (annul),
        .i_op0       (op0),
        .i_op1       (op1),
        .o_stall_req (stall),
        .o_ready     (rdy),
        .o_quot      (quot),
        .o_rem       (rem),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: integer division with truncation toward zero, remainder
    // carrying the dividend's sign; x/0 gives 0,0. Results are taken mod 2**32.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic ready_prev = 1'b0;
    always @(posedge clk) begin
        logic [63:0] want;
        #1;
        if (rdy && !ready_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got q=0x%0h r=0x%0h with nothing expected", quot, rem);
            end else begin
                want = exp_q.pop_front();
                check("result", {quot, rem}, want);
            end
        end
        ready_prev = rdy;
    end

    // ---------------- driver ----------------
    // Called at posedge+1. Launches a divide, scrambles the operand inputs
    // after launch, checks stall/latency, holds in DONE, then releases.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s, input int hold);
        int n;
        int lat;
        int stall_bad;
        logic [63:0] want;
        want = ref_div(a, b, s);
        exp_q.push_back(want);
        lat = (b == 32'd0) ? 2 : N + 1;
        op0 = a;
        op1 = b;
        sgn = s;
        start = 1'b1;
        #1;
        check("stall_at_launch", 64'(stall), 64'd1);
        n = 0;
        stall_bad = 0;
        while (!rdy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                op0 = $urandom;
                op1 = $urandom;
                sgn = 1'($urandom_range(0, 1));
            end
            if (!rdy && !stall) stall_bad++;
        end
        check("latency", 64'(n), 64'(lat));
        check("stall_while_busy", 64'(stall_bad), 64'd0);
        check("stall_low_on_ready", 64'(stall), 64'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        check("hold_ready", 64'(rdy), 64'd1);
        check("hold_result", {quot, rem}, want);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("ready_clear", 64'(rdy), 64'd0);
        check("idle_state", 64'(dbg_state), 64'd0);
        check("idle_keeps_result", {quot, rem}, want);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst = 1'b1;
        start = 1'b0;
        sgn = 1'b0;
        annul = 1'b0;
        op0 = '0;
        op1 = '0;
        #2;
        check("reset_ready", 64'(rdy), 64'd0);
        check("reset_result", {quot, rem}, 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_div(32'd100, 32'd7, 1'b0, 2);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0);
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 1);
        run_div(32'h1234, 32'd0, 1'b0, 1);
        run_div(32'h80000001, 32'd0, 1'b1, 0);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0);
        run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);

        // Annul at RUN iteration 10: no result, back to IDLE next edge
        op0 = 32'd1000;
        op1 = 32'd3;
        sgn = 1'b0;
        start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul = 1'b1;
        #1;
        check("annul_stall_low", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        check("annul_state_idle", 64'(dbg_state), 64'd0);
        check("annul_ready_low", 64'(rdy), 64'd0);
        annul = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("annul_no_ready", 64'(rdy), 64'd0);
        run_div(32'd9, 32'd3, 1'b0, 0);

        // Annul beats start in IDLE
        start = 1'b1;
        annul = 1'b1;
        op1 = 32'd5;
        @(posedge clk);
        #1;
        check("annul_priority_state", 64'(dbg_state), 64'd0);
        start = 1'b0;
        annul = 1'b0;

        // Async reset mid-RUN, between edges
        run_div(32'd77, 32'd5, 1'b0, 0);
        op0 = 32'hDEAD;
        op1 = 32'h77;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("midrun_rst_ready", 64'(rdy), 64'd0);
        check("midrun_rst_result", {quot, rem}, 64'd0);
        check("midrun_rst_state", 64'(dbg_state), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        #1;
        check("post_rst_stall_hi", 64'(stall), 64'd1);
        start = 1'b0;
        #1;
        check("post_rst_stall_lo", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        run_div(32'hFFFF0000, 32'd17, 1'b1, 1);

        // Randomized divides
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                3: b = $urandom >> $urandom_range(0, 31);
                4: b = -(32'($urandom_range(1, 100)));
                default: b = $urandom;
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
